// File: rtl/sensor_cond_pkg.sv
// Shared types, battery thresholds and the EMA shift clamp for the
// multi-channel sensor conditioner.
package sensor_cond_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEL  = 2'd1,
      UPD  = 2'd2
   } sc_state_t;

   localparam logic [11:0] LB_THRES_DEF = 12'hA98;
   localparam logic [11:0] LB_HYST_DEF  = 12'h010;

   function automatic logic [2:0] clamp_sh(input logic [2:0] sh, input logic [2:0] maxsh);
      return (sh > maxsh) ? maxsh : sh;
   endfunction

endpackage

// File: rtl/sensor_cond_mc_rr_arb.sv
// Round-robin picker: first requesting channel at or after ptr, wrapping
// modulo N. Purely combinational.
module rr_arb #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW:0] sum_s;
   logic [IW:0] pos_s;
   logic        hit_s;

   // scan channels in rotated order, keep the first hit
   always_comb begin
      gnt   = '0;
      idx   = '0;
      any   = 1'b0;
      sum_s = '0;
      pos_s = '0;
      hit_s = 1'b0;
      for (int k = 0; k < N; k++) begin
         sum_s = {1'b0, ptr} + (IW+1)'(k);
         pos_s = (sum_s >= (IW+1)'(N)) ? (sum_s - (IW+1)'(N)) : sum_s;
         hit_s = !any && req[pos_s[IW-1:0]];
         idx   = hit_s ? pos_s[IW-1:0] : idx;
         any   = any | hit_s;
      end
      gnt[idx] = any;
   end

endmodule

// File: rtl/sensor_cond_mc.sv
// Multi-channel EMA sensor conditioner with one shared, time-multiplexed
// datapath, plus low-battery-gated regulation error.
module sensor_cond_mc
   import sensor_cond_pkg::*;
#(
   parameter int          NCH      = 4,
   parameter int          DW       = 12,
   parameter int          MAXSH    = 5,
   parameter int          ERR_CH   = 0,
   parameter int          FAST_SIM = 1,
   parameter logic [DW-1:0] LB_THRES = DW'(LB_THRES_DEF),
   parameter logic [DW-1:0] LB_HYST  = DW'(LB_HYST_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH*DW-1:0] raw_in,
   input  logic [NCH*3-1:0]  shift_cfg,
   input  logic [NCH-1:0]    smpl_req,
   input  logic [NCH-1:0]    seed_req,
   input  logic [NCH-1:0]    tmr_en,
   input  logic [DW-1:0]     target,
   input  logic [DW-1:0]     batt,
   input  logic              err_en,
   output logic [NCH*DW-1:0] avg_out,
   output logic [NCH-1:0]    avg_vld,
   output logic [DW:0]       error,
   output logic              low_batt,
   output logic              busy
);

   localparam int AW = DW + MAXSH;
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TW = (FAST_SIM != 0) ? 16 : 22;

   sc_state_t         state_r, state_nxt;
   logic [TW-1:0]     tmr_r;
   logic [NCH-1:0]    smpl_pend_r, seed_pend_r;
   logic [IW-1:0]     ptr_r, ch_r;
   logic [DW-1:0]     raw_r;
   logic [2:0]        sh_r;
   logic              seed_r;
   logic [AW-1:0]     acc_r [NCH];
   logic [NCH*DW-1:0] avg_out_r;
   logic [NCH-1:0]    avg_vld_r;
   logic [DW:0]       error_r;
   logic              low_batt_r;

   logic [NCH-1:0]    pend_s, gnt_s, clr_s, tmr_set_s;
   logic [IW-1:0]     idx_s;
   logic              any_s;
   logic [AW-1:0]     acc_cur_s, acc_new_s;
   logic [DW-1:0]     avg_new_s;

   assign pend_s    = smpl_pend_r | seed_pend_r;
   assign tmr_set_s = (&tmr_r) ? tmr_en : '0;

   rr_arb #(.N(NCH), .IW(IW)) u_arb (
      .req (pend_s),
      .ptr (ptr_r),
      .gnt (gnt_s),
      .idx (idx_s),
      .any (any_s)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // next state and pending-clear for the channel latched in SEL
   always_comb begin
      state_nxt = state_r;
      clr_s     = '0;
      case (state_r)
         IDLE: state_nxt = any_s ? SEL : IDLE;
         SEL: begin
            clr_s     = gnt_s;
            state_nxt = any_s ? UPD : IDLE;
         end
         UPD:     state_nxt = any_s ? SEL : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // shared datapath for the channel currently in service
   always_comb begin
      acc_cur_s = acc_r[ch_r];
      if (seed_r) begin
         acc_new_s = AW'(raw_r) << sh_r;
      end else begin
         acc_new_s = acc_cur_s - (acc_cur_s >> sh_r) + AW'(raw_r);
      end
      avg_new_s = DW'(acc_new_s >> sh_r);
   end

   // sample timer, pending bits (set beats clear) and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         tmr_r       <= '0;
         smpl_pend_r <= '0;
         seed_pend_r <= '0;
         ptr_r       <= '0;
      end else begin
         tmr_r       <= tmr_r + TW'(1);
         smpl_pend_r <= (smpl_pend_r & ~clr_s) | smpl_req | tmr_set_s;
         seed_pend_r <= (seed_pend_r & ~clr_s) | seed_req;
         if (state_r == UPD) begin
            ptr_r <= (ch_r == IW'(NCH - 1)) ? '0 : ch_r + IW'(1);
         end
      end
   end

   // service latch in SEL, accumulator and average write-back in UPD
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_r      <= '0;
         raw_r     <= '0;
         sh_r      <= 3'd0;
         seed_r    <= 1'b0;
         avg_out_r <= '0;
         avg_vld_r <= '0;
         for (int i = 0; i < NCH; i++) begin
            acc_r[i] <= '0;
         end
      end else begin
         avg_vld_r <= '0;
         if (state_r == SEL) begin
            ch_r   <= idx_s;
            raw_r  <= raw_in[idx_s*DW +: DW];
            sh_r   <= clamp_sh(shift_cfg[idx_s*3 +: 3], 3'(MAXSH));
            seed_r <= seed_pend_r[idx_s];
         end
         if (state_r == UPD) begin
            acc_r[ch_r]               <= acc_new_s;
            avg_out_r[ch_r*DW +: DW]  <= avg_new_s;
            avg_vld_r[ch_r]           <= 1'b1;
         end
      end
   end

   // low-battery hysteresis and gated regulation error
   always_ff @(posedge clk) begin
      if (rst) begin
         low_batt_r <= 1'b0;
         error_r    <= '0;
      end else begin
         if (batt < LB_THRES) begin
            low_batt_r <= 1'b1;
         end else if ({1'b0, batt} >= ({1'b0, LB_THRES} + {1'b0, LB_HYST})) begin
            low_batt_r <= 1'b0;
         end
         if (low_batt_r || !err_en) begin
            error_r <= '0;
         end else begin
            error_r <= {1'b0, target} - {1'b0, avg_out_r[ERR_CH*DW +: DW]};
         end
      end
   end

   assign avg_out  = avg_out_r;
   assign avg_vld  = avg_vld_r;
   assign error    = error_r;
   assign low_batt = low_batt_r;
   assign busy     = (state_r != IDLE) | (|smpl_pend_r) | (|seed_pend_r);

endmodule
